series_tx_1011: RTL and testbench

//   Serial pattern transmitter: the source end of the 1011 serial-detect link.
//   - Accepts WIDTH-bit words over a valid/ready handshake.
//   - Shifts each word out MSB-first on a 1-bit series line, with idle gaps between words.
//   - Produces a golden exp_detect pulse and a pulse count for any 1011 detector on that line.
//   - exp_detect timing is selectable: Mealy (same cycle as the final 1) or Moore (next cycle).

---
 rtl/series_tx_1011.sv | 130 +++++++++++++
 tb/tb_series_tx_1011.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/series_tx_1011.sv
// Serial 1011 pattern transmitter: serializes words MSB-first
// and produces a golden detect pulse plus saturating hit count.
module series_tx_1011 #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter bit MEALY_FSM  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             series,
  output logic             series_valid,
  output logic             busy,
  output logic             exp_detect,
  output logic [7:0]       match_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [2:0]       r_hist;
  logic             r_det;
  logic [7:0]       r_cnt;

  state_t           w_state_n;
  logic [WIDTH-1:0] w_sreg_n;
  logic [CW-1:0]    w_bit_n;
  logic [GW-1:0]    w_gap_n;
  logic             w_ready;
  logic             w_series;
  logic             w_sv;
  logic             w_hit;
  logic             w_det;

  always_comb begin
    w_state_n = r_state;
    w_sreg_n  = r_sreg;
    w_bit_n   = r_bit_cnt;
    w_gap_n   = r_gap_cnt;
    w_ready   = 1'b0;
    w_series  = 1'b0;
    w_sv      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (in_valid) begin
          w_sreg_n  = in_data;
          w_bit_n   = BIT_LAST;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_series = r_sreg[WIDTH-1];
        w_sv     = 1'b1;
        w_sreg_n = r_sreg << 1;
        w_bit_n  = r_bit_cnt - 1'b1;
        if (r_bit_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_state_n = S_GAP;
            w_gap_n   = GAP_LAST;
          end else begin
            // seamless mode: accept the next word on the last bit
            w_ready = 1'b1;
            if (in_valid) begin
              w_sreg_n = in_data;
              w_bit_n  = BIT_LAST;
            end else begin
              w_state_n = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_n = S_IDLE;
        end else begin
          w_gap_n = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_hit = ({r_hist, w_series} == 4'b1011);
  assign w_det = MEALY_FSM ? w_hit : r_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_hist    <= '0;
      r_det     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_sreg    <= w_sreg_n;
      r_bit_cnt <= w_bit_n;
      r_gap_cnt <= w_gap_n;
      r_hist    <= {r_hist[1:0], w_series};
      r_det     <= w_hit;
      if (w_det && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign in_ready     = w_ready;
  assign series       = w_series;
  assign series_valid = w_sv;
  assign busy         = (r_state != S_IDLE);
  assign exp_detect   = w_det;
  assign match_cnt    = r_cnt;

endmodule

// File: tb/tb_series_tx_1011.sv
// Scoreboard bench for series_tx_1011: three instances cover
// Mealy/gap, Moore/gap and Mealy/seamless configurations.
module tb_series_tx_1011;

  typedef struct packed {
    logic [1:0] k;
    logic       s;
    logic       d;
  } exp_t;

  logic            clk = 1'b0;
  logic [2:0]      rst;
  logic [2:0]      vld;
  logic [7:0]      dat [3];
  logic [2:0]      rdy;
  logic [2:0]      ser;
  logic [2:0]      sv;
  logic [2:0]      bsy;
  logic [2:0]      det;
  logic [2:0][7:0] cnt;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  series_tx_1011 #(.WIDTH(8), .GAP_CYCLES(2), .MEALY_FSM(1'b1)) u_a (
    .clk(clk), .rst(rst[0]), .in_valid(vld[0]), .in_data(dat[0]),
    .in_ready(rdy[0]), .series(ser[0]), .series_valid(sv[0]),
    .busy(bsy[0]), .exp_detect(det[0]), .match_cnt(cnt[0])
  );

  series_tx_1011 #(.WIDTH(8), .GAP_CYCLES(2), .MEALY_FSM(1'b0)) u_b (
    .clk(clk), .rst(rst[1]), .in_valid(vld[1]), .in_data(dat[1]),
    .in_ready(rdy[1]), .series(ser[1]), .series_valid(sv[1]),
    .busy(bsy[1]), .exp_detect(det[1]), .match_cnt(cnt[1])
  );

  series_tx_1011 #(.WIDTH(8), .GAP_CYCLES(0), .MEALY_FSM(1'b1)) u_c (
    .clk(clk), .rst(rst[2]), .in_valid(vld[2]), .in_data(dat[2]),
    .in_ready(rdy[2]), .series(ser[2]), .series_valid(sv[2]),
    .busy(bsy[2]), .exp_detect(det[2]), .match_cnt(cnt[2])
  );

  // monitor: any shifted bit or detect pulse consumes one expectation
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (sv[k] || det[k]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out inst=%0d sv=%b ser=%b det=%b",
                   k, sv[k], ser[k], det[k]);
        end else begin
          e = q.pop_front();
          if (e.k != 2'(k) || !sv[k] || ser[k] != e.s
              || det[k] != e.d) begin
            errors++;
            $display("FAIL bit inst=%0d got sv=%b ser=%b det=%b %s",
                     k, sv[k], ser[k], det[k], "");
            $display("  want inst=%0d sv=1 ser=%b det=%b",
                     e.k, e.s, e.d);
          end
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(int k);
    chk("rst_ready", int'(rdy[k]), 1);
    chk("rst_series", int'(ser[k]), 0);
    chk("rst_sv", int'(sv[k]), 0);
    chk("rst_busy", int'(bsy[k]), 0);
    chk("rst_det", int'(det[k]), 0);
    chk("rst_cnt", int'(cnt[k]), 0);
  endtask

  // push nb expected bits, then offer the word until accepted
  task automatic send(int k, logic [7:0] d, logic [7:0] m,
                      int nb, output int waited);
    exp_t e;
    for (int i = 7; i >= 8 - nb; i--) begin
      e.k = 2'(k);
      e.s = d[i];
      e.d = m[i];
      q.push_back(e);
    end
    @(negedge clk);
    vld[k] = 1'b1;
    dat[k] = d;
    waited = 0;
    while (!rdy[k] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy[k]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst=%0d act=not_ready exp=ready", k);
    end
    @(posedge clk);
  endtask

  task automatic finish_word(int k, output int gaps,
                             output int busy_n);
    @(negedge clk);
    vld[k] = 1'b0;
    gaps   = 0;
    busy_n = 0;
    while (bsy[k] && busy_n < 100) begin
      busy_n++;
      if (!sv[k]) gaps++;
      @(negedge clk);
    end
    if (bsy[k]) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout inst=%0d act=busy exp=idle", k);
    end
  endtask

  initial begin
    int w, g, b, ex;
    rst = 3'b111;
    vld = 3'b000;
    for (int k = 0; k < 3; k++) dat[k] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst = 3'b000;

    // 1: Mealy, single hit on bit 4
    send(0, 8'b1011_0000, 8'b0001_0000, 8, w);
    finish_word(0, g, b);
    chk("t1_cnt", int'(cnt[0]), 1);
    chk("t1_gaps", g, 2);
    chk("t1_busy", b, 10);

    // 2: overlapping hits on bits 4 and 7
    send(0, 8'b1011_0110, 8'b0001_0010, 8, w);
    finish_word(0, g, b);
    chk("t2_cnt", int'(cnt[0]), 3);
    chk("t2_gaps", g, 2);

    // 3: Moore, hit delayed to bit 5
    send(1, 8'b1011_0000, 8'b0000_1000, 8, w);
    finish_word(1, g, b);
    chk("t3_cnt", int'(cnt[1]), 1);
    chk("t3_gaps", g, 2);

    // 4: seamless words, hit spans the boundary
    send(2, 8'b0000_0101, 8'b0000_0000, 8, w);
    chk("t4_w1_wait", w, 0);
    send(2, 8'b1000_0000, 8'b1000_0000, 8, w);
    chk("t4_ready_bit8", w, 7);
    chk("t4_sv_at_hs", int'(sv[2]), 1);
    finish_word(2, g, b);
    chk("t4_w2_busy", b, 8);
    chk("t4_gaps", g, 0);
    chk("t4_cnt", int'(cnt[2]), 1);

    // 5: reset after three bits discards the word and history
    send(0, 8'b1011_1111, 8'b0000_0000, 3, w);
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_reset(0);
    rst[0] = 1'b0;
    send(0, 8'b1000_0000, 8'b0000_0000, 8, w);
    finish_word(0, g, b);
    chk("t5_cnt", int'(cnt[0]), 0);

    // 6: saturation at 255
    for (int i = 0; i < 300; i++) begin
      send(0, 8'b1011_0000, 8'b0001_0000, 8, w);
      finish_word(0, g, b);
      ex = (i + 1 > 255) ? 255 : i + 1;
      chk("t6_cnt", int'(cnt[0]), ex);
    end

    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
